// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding, default sizes and parity helper for the SRAM bank
package sram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int PAR_MAX_W  = 1024;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sram_word_array.sv
// rtl/sram_word_array.sv - DEPTH x WORD_W storage, one sync write port, one sync-capture read port, no reset
module sram_word_array #(
    parameter  int WORD_W = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Callers only assert we_i/re_i with in-range addresses.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - SRAM bank controller: clear sweep, req/rsp handshake, tri-state read bus; SRAM_PARITY_EN adds parity
module sram_bank_ctrl
    import sram_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output tri   [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
`ifdef SRAM_PARITY_EN
    ,
    input  logic              par_inject
`endif
);

`ifdef SRAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              oor_q, oor_d;

    logic              hs;
    logic              in_range;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic [DATA_W-1:0] rd_word;
    logic              word_err;

    assign in_range  = {1'b0, req_addr} < DEPTH_C;
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q == ST_CLEAR);
    assign hs        = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (hs && !req_we) begin
                    state_d = ST_RESP;
                    oor_d   = !in_range;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // The sweep owns the write port while busy; afterwards only in-range write handshakes reach it.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = req_addr;
        arr_wdata = '0;
        if (state_q == ST_CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = cnt_q;
        end else if (hs && req_we && in_range) begin
            arr_we    = 1'b1;
`ifdef SRAM_PARITY_EN
            arr_wdata = {even_parity(PAR_MAX_W'(req_wdata)) ^ par_inject, req_wdata};
`else
            arr_wdata = req_wdata;
`endif
        end
    end

    assign arr_re = hs && !req_we && in_range;

    sram_word_array #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .raddr_i (req_addr),
        .rdata_o (arr_rdata)
    );

    // An out-of-range read leaves the array register stale, so its data and parity are masked.
    assign rd_word = oor_q ? '0 : arr_rdata[DATA_W-1:0];

`ifdef SRAM_PARITY_EN
    assign word_err = oor_q |
                      (arr_rdata[DATA_W] != even_parity(PAR_MAX_W'(arr_rdata[DATA_W-1:0])));
`else
    assign word_err = oor_q;
`endif

    assign rsp_err   = rsp_valid & word_err;
    assign rsp_rdata = rsp_valid ? rd_word : {DATA_W{1'bz}};

endmodule
